// File: rtl/imem_dual_rom_loader_if.sv
// rtl/imem_dual_rom_loader_if.sv - loader byte stream and dual fetch port bundle
interface imem_dual_rom_loader_if #(
  parameter int AW = 6,
  parameter int DW = 32
);
  logic          ld_valid;
  logic          ld_ready;
  logic [7:0]    ld_byte;
  logic          ld_last;
  logic [AW-1:0] ROM_A1;
  logic [AW-1:0] ROM_A2;
  logic [DW-1:0] ROM_RD1;
  logic [DW-1:0] ROM_RD2;

  modport master (
    output ld_valid, ld_byte, ld_last, ROM_A1, ROM_A2,
    input  ld_ready, ROM_RD1, ROM_RD2
  );

  modport slave (
    input  ld_valid, ld_byte, ld_last, ROM_A1, ROM_A2,
    output ld_ready, ROM_RD1, ROM_RD2
  );
endinterface

// File: rtl/imem_dual_rom_loader.sv
// rtl/imem_dual_rom_loader.sv - program store loaded from a byte stream, then served on two fetch ports
module imem_dual_rom_loader #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  imem_dual_rom_loader_if.slave bus,
  output logic          cpu_rst,
  output logic          load_done,
  output logic          load_err,
  output logic [AW:0]   word_count
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t        state_q;
  logic [1:0]    byte_idx_q;
  logic [23:0]   asm_q;
  logic [AW:0]   wc_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic          ld_ready_q;
  logic          cpu_rst_q;
  logic          load_done_q;
  logic          load_err_q;
  logic          store_full;

  assign store_full = (wc_q == (AW+1)'(DEPTH));

  // Status outputs are registered alongside the state so they always match it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_LOAD;
      byte_idx_q  <= 2'd0;
      asm_q       <= '0;
      wc_q        <= '0;
      ld_ready_q  <= 1'b1;
      cpu_rst_q   <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (state_q == S_LOAD && bus.ld_valid) begin
      if (store_full) begin
        state_q    <= S_ERR;
        ld_ready_q <= 1'b0;
        load_err_q <= 1'b1;
      end else if (byte_idx_q == 2'd3) begin
        mem_q[wc_q[AW-1:0]] <= {bus.ld_byte, asm_q};
        wc_q       <= wc_q + (AW+1)'(1);
        byte_idx_q <= 2'd0;
        asm_q      <= '0;
        if (bus.ld_last) begin
          state_q     <= S_RUN;
          ld_ready_q  <= 1'b0;
          cpu_rst_q   <= 1'b0;
          load_done_q <= 1'b1;
        end
      end else begin
        asm_q[{byte_idx_q, 3'b000} +: 8] <= bus.ld_byte;
        byte_idx_q <= byte_idx_q + 2'd1;
        // Program ended on a partial word.
        if (bus.ld_last) begin
          state_q    <= S_ERR;
          ld_ready_q <= 1'b0;
          load_err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.ld_ready = ld_ready_q;
  assign bus.ROM_RD1  = mem_q[bus.ROM_A1];
  assign bus.ROM_RD2  = mem_q[bus.ROM_A2];
  assign cpu_rst      = cpu_rst_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign word_count   = wc_q;
endmodule

// File: tb/tb_imem_dual_rom_loader.sv
// tb/tb_imem_dual_rom_loader.sv - randomized self-checking bench against a byte-queue program model
module tb_imem_dual_rom_loader;
  localparam int ML = 0, MR = 1, ME = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       cpu_rst, load_done, load_err;
  logic [6:0] word_count;

  imem_dual_rom_loader_if #(.AW(6), .DW(32)) bus ();

  imem_dual_rom_loader #(.AW(6), .DW(32)) dut (
    .CLK(CLK), .RST(RST), .bus(bus.slave),
    .cpu_rst(cpu_rst), .load_done(load_done), .load_err(load_err), .word_count(word_count)
  );

  always #5 CLK = ~CLK;

  int          vec = 0;
  int          err = 0;
  int          m_state;
  int          m_wc;
  logic [31:0] m_mem [64];
  logic [7:0]  m_bytes [$];

  function automatic void model_reset();
    m_state = ML;
    m_wc    = 0;
    m_bytes.delete();
    for (int i = 0; i < 64; i++) m_mem[i] = 32'h0;
  endfunction

  function automatic void model_accept(input logic [7:0] b, input logic last);
    if (m_state != ML) return;
    if (m_wc == 64) begin
      m_state = ME;
      return;
    end
    m_bytes.push_back(b);
    if (m_bytes.size() == 4) begin
      m_mem[m_wc] = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
      m_wc++;
      m_bytes.delete();
      if (last) m_state = MR;
    end else if (last) begin
      m_state = ME;
    end
  endfunction

  task automatic do_reset();
    RST = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_byte  = 8'($urandom);
    bus.ld_last  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    bus.ld_valid = 1'b0;
    model_reset();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input int max_gap);
    bus.ld_valid = 1'b1;
    bus.ld_byte  = b;
    bus.ld_last  = last;
    @(posedge CLK);
    model_accept(b, last);
    #1;
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    bus.ld_byte  = 8'($urandom);
    repeat ($urandom_range(0, max_gap)) @(posedge CLK);
    #0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic last, input int max_gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], last && (k == 3), max_gap);
  endtask

  task automatic test_reset();
    do_reset();
    bus.ROM_A1 = 6'h00;
    bus.ROM_A2 = 6'h3F;
    #1;
    vec++; if (bus.ld_ready !== 1'b1)  begin err++; $display("FAIL reset ld_ready got %b exp 1", bus.ld_ready); end
    vec++; if (cpu_rst !== 1'b1)       begin err++; $display("FAIL reset cpu_rst got %b exp 1", cpu_rst); end
    vec++; if (load_done !== 1'b0)     begin err++; $display("FAIL reset load_done got %b exp 0", load_done); end
    vec++; if (load_err !== 1'b0)      begin err++; $display("FAIL reset load_err got %b exp 0", load_err); end
    vec++; if (word_count !== 7'd0)    begin err++; $display("FAIL reset word_count got %0d exp 0", word_count); end
    vec++; if (bus.ROM_RD1 !== 32'h0)  begin err++; $display("FAIL reset rd1 got %h exp 0", bus.ROM_RD1); end
    vec++; if (bus.ROM_RD2 !== 32'h0)  begin err++; $display("FAIL reset rd2 got %h exp 0", bus.ROM_RD2); end
  endtask

  task automatic test_two_words();
    do_reset();
    send_word(32'h12345678, 1'b0, 3);
    send_word(32'hDEADBEEF, 1'b1, 3);
    #1;
    vec++; if (m_state != MR)             begin err++; $display("FAIL two_words model_state got %0d exp %0d", m_state, MR); end
    vec++; if (word_count !== 7'd2)       begin err++; $display("FAIL two_words word_count got %0d exp 2", word_count); end
    vec++; if (cpu_rst !== 1'b0)          begin err++; $display("FAIL two_words cpu_rst got %b exp 0", cpu_rst); end
    vec++; if (load_done !== 1'b1)        begin err++; $display("FAIL two_words load_done got %b exp 1", load_done); end
    vec++; if (bus.ld_ready !== 1'b0)     begin err++; $display("FAIL two_words ld_ready got %b exp 0", bus.ld_ready); end
    bus.ROM_A1 = 6'd0; bus.ROM_A2 = 6'd1; #1;
    vec++; if (bus.ROM_RD1 !== 32'h12345678) begin err++; $display("FAIL two_words rd1[0] got %h exp 12345678", bus.ROM_RD1); end
    vec++; if (bus.ROM_RD2 !== 32'hDEADBEEF) begin err++; $display("FAIL two_words rd2[1] got %h exp deadbeef", bus.ROM_RD2); end
    bus.ROM_A1 = 6'd1; #1;
    vec++; if (bus.ROM_RD1 !== 32'hDEADBEEF || bus.ROM_RD2 !== 32'hDEADBEEF)
      begin err++; $display("FAIL two_words same_addr got %h/%h exp deadbeef", bus.ROM_RD1, bus.ROM_RD2); end
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'($urandom), 1);
    #1;
    vec++; if (word_count !== 7'd2 || load_done !== 1'b1)
      begin err++; $display("FAIL two_words run_ignore wc %0d done %b exp 2/1", word_count, load_done); end
    for (int a = 0; a < 64; a++) begin
      bus.ROM_A1 = a[5:0]; bus.ROM_A2 = 6'(63 - a); #1;
      vec++; if (bus.ROM_RD1 !== m_mem[a]) begin err++; $display("FAIL two_words mem[%0d] got %h exp %h", a, bus.ROM_RD1, m_mem[a]); end
    end
  endtask

  task automatic test_partial_err();
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), i == 5, 2);
    bus.ROM_A1 = 6'd1; bus.ROM_A2 = 6'd0; #1;
    vec++; if (load_err !== 1'b1)      begin err++; $display("FAIL partial load_err got %b exp 1", load_err); end
    vec++; if (cpu_rst !== 1'b1)       begin err++; $display("FAIL partial cpu_rst got %b exp 1", cpu_rst); end
    vec++; if (bus.ld_ready !== 1'b0)  begin err++; $display("FAIL partial ld_ready got %b exp 0", bus.ld_ready); end
    vec++; if (load_done !== 1'b0)     begin err++; $display("FAIL partial load_done got %b exp 0", load_done); end
    vec++; if (word_count !== 7'd1)    begin err++; $display("FAIL partial word_count got %0d exp 1", word_count); end
    vec++; if (bus.ROM_RD1 !== 32'h0)  begin err++; $display("FAIL partial mem[1] got %h exp 0", bus.ROM_RD1); end
    vec++; if (bus.ROM_RD2 !== m_mem[0]) begin err++; $display("FAIL partial mem[0] got %h exp %h", bus.ROM_RD2, m_mem[0]); end
  endtask

  task automatic test_full_load();
    do_reset();
    for (int i = 0; i < 64; i++) send_word(32'h1000_0000 + i, i == 63, 0);
    bus.ROM_A1 = 6'h3F; bus.ROM_A2 = 6'h00; #1;
    vec++; if (load_done !== 1'b1 || load_err !== 1'b0)
      begin err++; $display("FAIL full_run done/err got %b/%b exp 1/0", load_done, load_err); end
    vec++; if (word_count !== 7'd64)       begin err++; $display("FAIL full_run word_count got %0d exp 64", word_count); end
    vec++; if (bus.ROM_RD1 !== 32'h1000003F) begin err++; $display("FAIL full_run rd1[3f] got %h exp 1000003f", bus.ROM_RD1); end
    for (int a = 0; a < 64; a++) begin
      bus.ROM_A2 = a[5:0]; #1;
      vec++; if (bus.ROM_RD2 !== m_mem[a]) begin err++; $display("FAIL full_run mem[%0d] got %h exp %h", a, bus.ROM_RD2, m_mem[a]); end
    end
    do_reset();
    for (int i = 0; i < 64; i++) send_word(32'h1000_0000 + i, 1'b0, 0);
    #1;
    vec++; if (bus.ld_ready !== 1'b1 || word_count !== 7'd64)
      begin err++; $display("FAIL full_pending ready/wc got %b/%0d exp 1/64", bus.ld_ready, word_count); end
    send_byte(8'hA5, 1'b0, 0);
    bus.ROM_A1 = 6'd0; bus.ROM_A2 = 6'h3F; #1;
    vec++; if (load_err !== 1'b1 || cpu_rst !== 1'b1)
      begin err++; $display("FAIL overflow err/cpu_rst got %b/%b exp 1/1", load_err, cpu_rst); end
    vec++; if (word_count !== 7'd64)         begin err++; $display("FAIL overflow word_count got %0d exp 64", word_count); end
    vec++; if (bus.ROM_RD1 !== 32'h10000000) begin err++; $display("FAIL overflow mem[0] got %h exp 10000000", bus.ROM_RD1); end
    vec++; if (bus.ROM_RD2 !== m_mem[63])    begin err++; $display("FAIL overflow mem[3f] got %h exp %h", bus.ROM_RD2, m_mem[63]); end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    for (int i = 0; i < 3; i++) send_word($urandom, 1'b0, 1);
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    do_reset();
    #1;
    vec++; if (bus.ld_ready !== 1'b1 || cpu_rst !== 1'b1)
      begin err++; $display("FAIL midrst ready/cpu_rst got %b/%b exp 1/1", bus.ld_ready, cpu_rst); end
    vec++; if (word_count !== 7'd0) begin err++; $display("FAIL midrst word_count got %0d exp 0", word_count); end
    for (int a = 0; a < 64; a++) begin
      bus.ROM_A1 = a[5:0]; #1;
      vec++; if (bus.ROM_RD1 !== 32'h0) begin err++; $display("FAIL midrst mem[%0d] got %h exp 0", a, bus.ROM_RD1); end
    end
    send_word(32'hAABBCCDD, 1'b1, 2);
    bus.ROM_A1 = 6'd0; bus.ROM_A2 = 6'd1; #1;
    vec++; if (bus.ROM_RD1 !== 32'hAABBCCDD) begin err++; $display("FAIL midrst fresh mem[0] got %h exp aabbccdd", bus.ROM_RD1); end
    vec++; if (bus.ROM_RD2 !== 32'h0)        begin err++; $display("FAIL midrst mem[1] got %h exp 0", bus.ROM_RD2); end
    vec++; if (load_done !== 1'b1 || word_count !== 7'd1)
      begin err++; $display("FAIL midrst done/wc got %b/%0d exp 1/1", load_done, word_count); end
  endtask

  task automatic test_err_recover();
    logic [31:0] w;
    do_reset();
    send_byte(8'h55, 1'b1, 0);
    #1;
    vec++; if (load_err !== 1'b1) begin err++; $display("FAIL recover pre_err got %b exp 1", load_err); end
    do_reset();
    w = $urandom;
    send_word(w, 1'b1, 2);
    bus.ROM_A1 = 6'd0; #1;
    vec++; if (load_err !== 1'b0 || load_done !== 1'b1 || cpu_rst !== 1'b0)
      begin err++; $display("FAIL recover err/done/cpu_rst got %b/%b/%b exp 0/1/0", load_err, load_done, cpu_rst); end
    vec++; if (bus.ROM_RD1 !== w) begin err++; $display("FAIL recover mem[0] got %h exp %h", bus.ROM_RD1, w); end
  endtask

  task automatic test_random_programs();
    int nbytes, mode;
    for (int r = 0; r < 6; r++) begin
      do_reset();
      mode   = $urandom_range(0, 2);
      nbytes = 4 * $urandom_range(1, 66);
      if (mode == 1) nbytes = nbytes - $urandom_range(1, 3);
      if (mode == 2) nbytes = nbytes + 1;
      for (int i = 0; i < nbytes; i++) send_byte(8'($urandom), (mode != 2) && (i == nbytes - 1), 1);
      #1;
      vec++; if (bus.ld_ready !== (m_state == ML) || cpu_rst !== (m_state != MR) ||
                 load_done !== (m_state == MR) || load_err !== (m_state == ME))
        begin err++; $display("FAIL random[%0d] status rdy/rst/done/err got %b%b%b%b model_state %0d", r, bus.ld_ready, cpu_rst, load_done, load_err, m_state); end
      vec++; if (word_count !== 7'(m_wc)) begin err++; $display("FAIL random[%0d] word_count got %0d exp %0d", r, word_count, m_wc); end
      for (int a = 0; a < 64; a++) begin
        bus.ROM_A1 = a[5:0]; bus.ROM_A2 = 6'($urandom); #1;
        vec++; if (bus.ROM_RD1 !== m_mem[a] || bus.ROM_RD2 !== m_mem[bus.ROM_A2])
          begin err++; $display("FAIL random[%0d] read a1=%0d got %h exp %h a2=%0d got %h exp %h", r, a, bus.ROM_RD1, m_mem[a], bus.ROM_A2, bus.ROM_RD2, m_mem[bus.ROM_A2]); end
      end
    end
  endtask

  initial begin
    bus.ld_valid = 1'b0;
    bus.ld_byte  = 8'h00;
    bus.ld_last  = 1'b0;
    bus.ROM_A1   = '0;
    bus.ROM_A2   = '0;
    model_reset();
    test_reset();
    test_two_words();
    test_partial_err();
    test_full_load();
    test_reset_mid_word();
    test_err_recover();
    test_random_programs();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
